perceptron_seq_ctrl: RTL

Sequencing controller for the 20-input, 8-neuron letter-recognition perceptron layer. It owns the signed weight array and evaluates neurons serially, one MAC per cycle, over a single shared accumulator. It thresholds each neuron and, when learning is requested, applies the perceptron update rule to mismatching neurons. It sits between the host/letter source and the classification output, and replaces the fully parallel per-clock evaluation.

---
 rtl/perceptron_seq_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/perceptron_seq_ctrl.sv
// Serial perceptron layer controller: one MAC per cycle over a shared accumulator,
// thresholding and optional perceptron-rule learning. Define PERCEPTRON_SAT_EN to saturate weight updates.
module perceptron_seq_ctrl #(
  parameter int unsigned N_IN      = 20,
  parameter int unsigned N_OUT     = 8,
  parameter int unsigned W_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int          THRESH    = 8000,
  parameter int unsigned LRATE     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_IN-1:0]           letter,
  input  logic                      start,
  input  logic                      learn,
  input  logic [N_OUT-1:0]          target,
  input  logic                      wr,
  input  logic [4:0]                wr_i,
  input  logic [2:0]                wr_j,
  input  logic signed [W_WIDTH-1:0] wr_data,
  output logic [N_OUT-1:0]          out1,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                upd_cnt
);

  localparam int unsigned I_W = $clog2(N_IN);
  localparam int unsigned J_W = $clog2(N_OUT);
  localparam logic signed [ACC_WIDTH-1:0] THR = ACC_WIDTH'(THRESH);
`ifdef PERCEPTRON_SAT_EN
  localparam logic signed [W_WIDTH:0] W_MAX = {2'b00, {(W_WIDTH-1){1'b1}}};
  localparam logic signed [W_WIDTH:0] W_MIN = {2'b11, {(W_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MAC, S_COMPARE, S_UPDATE, S_DONE} state_t;

  state_t state, state_n;

  logic signed [W_WIDTH-1:0]   w [N_IN][N_OUT];
  logic signed [ACC_WIDTH-1:0] acc;
  logic [I_W-1:0]              i;
  logic [J_W-1:0]              j;
  logic [N_IN-1:0]             letter_q;
  logic                        learn_q;
  logic [N_OUT-1:0]            target_q;

  logic signed [W_WIDTH-1:0]   w_cur_c, step_c, w_new_c;
  logic signed [ACC_WIDTH-1:0] ext_c;
  logic                        fire_c, mismatch_c, last_i_c, last_j_c;
`ifdef PERCEPTRON_SAT_EN
  logic signed [W_WIDTH:0]     sum_c;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic plus the shared MAC/update arithmetic
  always_comb begin
    state_n    = state;
    w_cur_c    = w[i][j];
    ext_c      = letter_q[i] ? ACC_WIDTH'(w_cur_c) : '0;
    fire_c     = acc > THR;
    mismatch_c = learn_q && (fire_c != target_q[j]);
    last_i_c   = (i == I_W'(N_IN - 1));
    last_j_c   = (j == J_W'(N_OUT - 1));
    step_c     = target_q[j] ? W_WIDTH'(LRATE) : -W_WIDTH'(LRATE);
`ifdef PERCEPTRON_SAT_EN
    sum_c      = {w_cur_c[W_WIDTH-1], w_cur_c} + {step_c[W_WIDTH-1], step_c};
    if (sum_c > W_MAX)      w_new_c = W_MAX[W_WIDTH-1:0];
    else if (sum_c < W_MIN) w_new_c = W_MIN[W_WIDTH-1:0];
    else                    w_new_c = sum_c[W_WIDTH-1:0];
`else
    w_new_c    = w_cur_c + step_c;
`endif
    case (state)
      S_IDLE:    if (start) state_n = S_CLEAR;
      S_CLEAR:   state_n = S_MAC;
      S_MAC:     if (last_i_c) state_n = S_COMPARE;
      S_COMPARE: begin
        if (mismatch_c)    state_n = S_UPDATE;
        else if (last_j_c) state_n = S_DONE;
        else               state_n = S_MAC;
      end
      S_UPDATE:  if (last_i_c) state_n = last_j_c ? S_DONE : S_MAC;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Datapath: weights, accumulator, indices, latched inputs and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < int'(N_IN); a++)
        for (int b = 0; b < int'(N_OUT); b++)
          w[a][b] <= '0;
      acc      <= '0;
      i        <= '0;
      j        <= '0;
      letter_q <= '0;
      learn_q  <= 1'b0;
      target_q <= '0;
      out1     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      upd_cnt  <= '0;
    end else begin
      busy <= (state_n != S_IDLE);
      done <= (state_n == S_DONE);
      case (state)
        S_IDLE: begin
          if (wr && (32'(wr_i) < N_IN)) w[wr_i][wr_j] <= wr_data;
          if (start) begin
            letter_q <= letter;
            learn_q  <= learn;
            target_q <= target;
          end
        end
        S_CLEAR: begin
          acc     <= '0;
          i       <= '0;
          j       <= '0;
          upd_cnt <= '0;
        end
        S_MAC: begin
          acc <= acc + ext_c;
          i   <= last_i_c ? '0 : i + 1'b1;
        end
        S_COMPARE: begin
          out1[j] <= fire_c;
          i       <= '0;
          if (mismatch_c) begin
            upd_cnt <= upd_cnt + 4'd1;
          end else if (!last_j_c) begin
            j   <= j + 1'b1;
            acc <= '0;
          end
        end
        S_UPDATE: begin
          if (letter_q[i]) w[i][j] <= w_new_c;
          if (last_i_c) begin
            i   <= '0;
            acc <= '0;
            if (!last_j_c) j <= j + 1'b1;
          end else begin
            i <= i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
